// File: rtl/conv_pkg.sv
// Types and defaults shared by the convolution job controller and the conv engine.
package conv_pkg;

    localparam int unsigned JOB_W_DEFAULT   = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 1024;

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWait,
        StGap,
        StFin
    } conv_state_e;

endpackage

// File: rtl/conv_timeout_cnt.sv
// Per-job watchdog counter: counts enabled cycles and flags the last allowed cycle.
module conv_timeout_cnt #(
    parameter int unsigned TIMEOUT = conv_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;

    // Saturates on the last cycle so a held enable can never wrap back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/conv_job_ctrl.sv
// Sequences a batch of conv engine jobs: one start pulse per job, watchdog abort, done pulse.
module conv_job_ctrl
    import conv_pkg::*;
#(
    parameter int unsigned JOB_W   = JOB_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [JOB_W-1:0] num_jobs,
    output logic             start,
    input  logic             finish,
    output logic [JOB_W-1:0] job_idx,
    output logic [JOB_W-1:0] jobs_done,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam logic [JOB_W-1:0] ONE = JOB_W'(1);

    conv_state_e      state_q, state_d;
    logic [JOB_W-1:0] num_q, num_d;
    logic [JOB_W-1:0] idx_d, cnt_d;
    logic             err_d;
    logic             tmr_clear, tmr_en, tmr_expired;

    assign tmr_clear = (state_q == StLaunch);
    assign tmr_en    = (state_q == StWait) && !finish;

    conv_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmr_clear),
        .enable  (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        idx_d   = job_idx;
        cnt_d   = jobs_done;
        err_d   = timeout_err;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    num_d   = num_jobs;
                    idx_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (num_jobs != '0) ? StLaunch : StFin;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                // A finish on the expiry cycle wins over the abort.
                if (finish) begin
                    cnt_d = jobs_done + ONE;
                    if (job_idx == num_q - ONE) begin
                        state_d = StFin;
                    end else begin
                        idx_d   = job_idx + ONE;
                        state_d = StGap;
                    end
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    state_d = StFin;
                end
            end
            StGap:   state_d = StLaunch;
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            num_q       <= '0;
            job_idx     <= '0;
            jobs_done   <= '0;
            timeout_err <= 1'b0;
            start       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            job_idx     <= idx_d;
            jobs_done   <= cnt_d;
            timeout_err <= err_d;
            start       <= (state_d == StLaunch);
            busy        <= (state_d != StIdle);
            done        <= (state_d == StFin);
        end
    end

endmodule
